// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM operand forwarding, load-use bubble insertion and bubble counter
module id_ex_stage #(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       rf_a,
  input  logic [31:0]       rf_b,
  input  logic [31:0]       ex_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_we,
  input  logic [31:0]       mem_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_op_a,
  output logic [31:0]       ex_op_b,
  output logic [4:0]        ex_rd,
  output logic              ex_rd_we,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       bubble_count
);
  logic        ex_live;
  logic        mem_live;
  logic        hazard;
  logic [31:0] op_a;
  logic [31:0] op_b;
  assign ex_live  = ex_valid & ex_rd_we & (ex_rd != 5'd0);
  assign mem_live = mem_we & (mem_rd != 5'd0);
  assign hazard   = id_valid & ex_live & ex_is_load &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign id_ready = ex_ready & ~hazard;
  // a held load has no result yet, so only non-load EX results are forwarded
  always_comb begin
    op_a = (id_rs1 == 5'd0) ? 32'd0 :
           (ex_live & ~ex_is_load & (id_rs1 == ex_rd)) ? ex_result :
           (mem_live & (id_rs1 == mem_rd)) ? mem_data : rf_a;
    op_b = (id_rs2 == 5'd0) ? 32'd0 :
           (ex_live & ~ex_is_load & (id_rs2 == ex_rd)) ? ex_result :
           (mem_live & (id_rs2 == mem_rd)) ? mem_data : rf_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_rd        <= '0;
      ex_rd_we     <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_ctrl      <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_ready) begin
      if (hazard) begin
        ex_valid <= 1'b0;
        if (~&bubble_count) bubble_count <= bubble_count + 32'd1;
      end else begin
        ex_valid   <= id_valid;
        ex_pc      <= id_pc;
        ex_imm     <= id_imm;
        ex_op_a    <= op_a;
        ex_op_b    <= op_b;
        ex_rd      <= id_rd;
        ex_rd_we   <= id_rd_we;
        ex_is_load <= id_is_load;
        ex_ctrl    <= id_ctrl;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors, corner sequences and randomized reference-model check of id_ex_stage
module tb_id_ex_stage;
  localparam int CW = 16;
  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_ready;
  logic [31:0]   id_pc, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_rd_we, id_is_load;
  logic [CW-1:0] id_ctrl;
  logic [31:0]   rf_a, rf_b, ex_result;
  logic [4:0]    mem_rd;
  logic          mem_we;
  logic [31:0]   mem_data;
  logic          ex_ready, flush;
  logic          ex_valid;
  logic [31:0]   ex_pc, ex_imm, ex_op_a, ex_op_b;
  logic [4:0]    ex_rd;
  logic          ex_rd_we, ex_is_load;
  logic [CW-1:0] ex_ctrl;
  logic [31:0]   bubble_count;

  id_ex_stage #(.CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .rf_a(rf_a), .rf_b(rf_b),
    .ex_result(ex_result), .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rs;
    logic [31:0] rf;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [31:0] exr;
    logic [31:0] exp_op;
  } vec_t;
  vec_t tbl[7];

  typedef struct {
    logic          v;
    logic [31:0]   pc, imm, a, b;
    logic [4:0]    rd;
    logic          we, ld;
    logic [CW-1:0] ctrl;
    logic [31:0]   bc;
  } mdl_t;
  mdl_t m;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_pc = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_rd_we = 0; id_is_load = 0; id_ctrl = 0;
    rf_a = 0; rf_b = 0; ex_result = 0; mem_rd = 0; mem_we = 0; mem_data = 0;
    ex_ready = 1; flush = 0;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_valid"}, 32'(ex_valid), 0);
    chk({n, "_pc"}, ex_pc, 0);
    chk({n, "_imm"}, ex_imm, 0);
    chk({n, "_op_a"}, ex_op_a, 0);
    chk({n, "_op_b"}, ex_op_b, 0);
    chk({n, "_rd"}, 32'(ex_rd), 0);
    chk({n, "_rd_we"}, 32'(ex_rd_we), 0);
    chk({n, "_is_load"}, 32'(ex_is_load), 0);
    chk({n, "_ctrl"}, 32'(ex_ctrl), 0);
    chk({n, "_bubbles"}, bubble_count, 0);
  endtask

  // issue "lw rd" then a consumer of rd, producing one bubble
  task automatic load_use(input logic [4:0] r);
    idle(); id_valid = 1; id_rd = r; id_rd_we = 1; id_is_load = 1;
    tick();
    idle(); id_valid = 1; id_rs1 = r; id_use_rs1 = 1; id_rd = 5'd9; id_rd_we = 1;
    tick();
  endtask

  function automatic logic [31:0] model_op(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 0;
    if (m.v && m.we && m.rd != 0 && !m.ld && m.rd == rs) return ex_result;
    if (mem_we && mem_rd != 0 && mem_rd == rs) return mem_data;
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic dep1, dep2;
    dep1 = id_use_rs1 && id_rs1 == m.rd;
    dep2 = id_use_rs2 && id_rs2 == m.rd;
    return id_valid && m.v && m.we && m.rd != 0 && m.ld && (dep1 || dep2);
  endfunction

  initial begin
    int exp_bc;
    logic hz;
    mdl_t nxt;
    tbl[0] = '{rs: 5'd7, rf: 32'h11, mwe: 1, mrd: 5'd7, md: 32'hAA, exr: 32'hBB, exp_op: 32'hBB};
    tbl[1] = '{rs: 5'd8, rf: 32'h11, mwe: 1, mrd: 5'd8, md: 32'hAA, exr: 32'hBB, exp_op: 32'hAA};
    tbl[2] = '{rs: 5'd0, rf: 32'h5,  mwe: 1, mrd: 5'd0, md: 32'hFF, exr: 32'hBB, exp_op: 32'h0};
    tbl[3] = '{rs: 5'd9, rf: 32'h55, mwe: 1, mrd: 5'd8, md: 32'hAA, exr: 32'hBB, exp_op: 32'h55};
    tbl[4] = '{rs: 5'd7, rf: 32'h11, mwe: 0, mrd: 5'd7, md: 32'hAA, exr: 32'hCC, exp_op: 32'hCC};
    tbl[5] = '{rs: 5'd8, rf: 32'h66, mwe: 0, mrd: 5'd8, md: 32'hAA, exr: 32'hBB, exp_op: 32'h66};
    tbl[6] = '{rs: 5'd3, rf: 32'h77, mwe: 1, mrd: 5'd3, md: 32'h1234, exr: 32'hBB, exp_op: 32'h1234};

    idle(); rst = 1;
    tick(); tick();
    chk_zero("reset");
    chk("reset_id_ready", 32'(id_ready), 1);
    rst = 0;

    // back-to-back dependent ALU ops
    id_valid = 1; id_rd = 5; id_rd_we = 1; id_pc = 32'h100; id_imm = 1; id_ctrl = 16'hA5A5;
    tick();
    chk("addi_valid", 32'(ex_valid), 1);
    chk("addi_rd", 32'(ex_rd), 5);
    chk("addi_pc", ex_pc, 32'h100);
    chk("addi_ctrl", 32'(ex_ctrl), 32'hA5A5);
    idle(); id_valid = 1; id_rs1 = 5; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = 6; id_rd_we = 1; id_pc = 32'h104; ex_result = 32'h10;
    #1 chk("dep_id_ready", 32'(id_ready), 1);
    tick();
    chk("dep_op_a", ex_op_a, 32'h10);
    chk("dep_op_b", ex_op_b, 32'h10);
    chk("dep_valid", 32'(ex_valid), 1);
    chk("dep_bubbles", bubble_count, 0);

    // forwarding table with a held non-load writing x7
    idle(); id_valid = 1; id_rd = 7; id_rd_we = 1;
    tick();
    foreach (tbl[i]) begin
      idle(); id_valid = 1; id_rd = 7; id_rd_we = 1; id_pc = 32'(i);
      id_rs1 = tbl[i].rs; id_rs2 = tbl[i].rs; id_use_rs1 = 1; id_use_rs2 = 1;
      rf_a = tbl[i].rf; rf_b = tbl[i].rf; mem_we = tbl[i].mwe; mem_rd = tbl[i].mrd;
      mem_data = tbl[i].md; ex_result = tbl[i].exr;
      tick();
      chk($sformatf("tbl%0d_op_a", i), ex_op_a, tbl[i].exp_op);
      chk($sformatf("tbl%0d_op_b", i), ex_op_b, tbl[i].exp_op);
      chk($sformatf("tbl%0d_valid", i), 32'(ex_valid), 1);
    end

    // load-use on rs2
    idle(); id_valid = 1; id_rd = 3; id_rd_we = 1; id_is_load = 1;
    tick();
    idle(); id_valid = 1; id_rs2 = 3; id_use_rs2 = 1; id_rd = 4; id_rd_we = 1;
    id_pc = 32'h300; rf_b = 32'hDEAD;
    #1 chk("lu_id_ready", 32'(id_ready), 0);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubbles", bubble_count, 1);
    mem_rd = 3; mem_we = 1; mem_data = 32'h1234;
    #1 chk("lu_retry_ready", 32'(id_ready), 1);
    tick();
    chk("lu_valid", 32'(ex_valid), 1);
    chk("lu_op_b", ex_op_b, 32'h1234);
    chk("lu_rd", 32'(ex_rd), 4);
    chk("lu_bubbles2", bubble_count, 1);

    // backpressure holds everything
    idle(); ex_ready = 0; id_valid = 1; id_pc = 32'h999; id_rd = 9; id_rd_we = 1; rf_b = 32'h5;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_id_ready", 32'(id_ready), 0);
      tick();
      chk("bp_valid", 32'(ex_valid), 1);
      chk("bp_pc", ex_pc, 32'h300);
      chk("bp_op_b", ex_op_b, 32'h1234);
      chk("bp_rd", 32'(ex_rd), 4);
      chk("bp_bubbles", bubble_count, 1);
    end

    // hold beats hazard
    idle(); id_valid = 1; id_rd = 2; id_rd_we = 1; id_is_load = 1;
    tick();
    idle(); ex_ready = 0; id_valid = 1; id_rs1 = 2; id_use_rs1 = 1;
    tick();
    chk("hold_hz_valid", 32'(ex_valid), 1);
    chk("hold_hz_load", 32'(ex_is_load), 1);
    chk("hold_hz_bubbles", bubble_count, 1);
    ex_ready = 1;
    tick();
    chk("hold_hz_release_valid", 32'(ex_valid), 0);
    chk("hold_hz_release_bubbles", bubble_count, 2);

    // flush kills the incoming instruction, even under backpressure
    idle(); id_valid = 1; id_rd = 5; id_rd_we = 1;
    tick();
    flush = 1;
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    idle(); id_valid = 1;
    tick();
    flush = 1; ex_ready = 0;
    tick();
    chk("flush_bp_valid", 32'(ex_valid), 0);
    chk("flush_bubbles", bubble_count, 2);

    // drive bubble_count to 5 then reset with a valid held instruction
    exp_bc = 2;
    while (exp_bc < 5) begin
      load_use(5'd3);
      exp_bc++;
    end
    chk("five_bubbles", bubble_count, 5);
    idle(); id_valid = 1; id_pc = 32'h44; id_rd = 1; id_rd_we = 1; rf_a = 32'h9;
    tick();
    chk("pre_rst_valid", 32'(ex_valid), 1);
    rst = 1;
    tick();
    chk_zero("midrst");
    rst = 0;

    // saturation
    idle(); id_valid = 1; id_rd = 3; id_rd_we = 1; id_is_load = 1;
    tick();
    force dut.bubble_count = 32'hFFFF_FFFF;
    #1 release dut.bubble_count;
    idle(); id_valid = 1; id_rs1 = 3; id_use_rs1 = 1;
    tick();
    chk("sat_bubbles", bubble_count, 32'hFFFF_FFFF);
    chk("sat_valid", 32'(ex_valid), 0);

    // randomized run against the reference model
    idle(); rst = 1;
    tick();
    m = '{default: '0};
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 9) == 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_pc = $urandom; id_imm = $urandom; id_ctrl = CW'($urandom);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_rd_we = ($urandom_range(0, 3) != 0); id_is_load = ($urandom_range(0, 2) == 0);
      rf_a = $urandom; rf_b = $urandom; ex_result = $urandom;
      mem_rd = 5'($urandom_range(0, 3)); mem_we = 1'($urandom); mem_data = $urandom;
      #1;
      hz = model_hazard();
      chk("rnd_id_ready", 32'(id_ready), 32'(ex_ready && !hz));
      nxt = m;
      if (rst) nxt = '{default: '0};
      else if (flush) nxt.v = 0;
      else if (!ex_ready) nxt = m;
      else if (hz) begin
        nxt.v = 0;
        if (m.bc != 32'hFFFF_FFFF) nxt.bc = m.bc + 1;
      end else begin
        nxt = '{v: id_valid, pc: id_pc, imm: id_imm, a: model_op(id_rs1, rf_a),
                b: model_op(id_rs2, rf_b), rd: id_rd, we: id_rd_we, ld: id_is_load,
                ctrl: id_ctrl, bc: m.bc};
      end
      tick();
      m = nxt;
      chk("rnd_valid", 32'(ex_valid), 32'(m.v));
      chk("rnd_bubbles", bubble_count, m.bc);
      if (m.v) begin
        chk("rnd_pc", ex_pc, m.pc);
        chk("rnd_imm", ex_imm, m.imm);
        chk("rnd_op_a", ex_op_a, m.a);
        chk("rnd_op_b", ex_op_b, m.b);
        chk("rnd_rd", 32'(ex_rd), 32'(m.rd));
        chk("rnd_rd_we", 32'(ex_rd_we), 32'(m.we));
        chk("rnd_is_load", 32'(ex_is_load), 32'(m.ld));
        chk("rnd_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
